// File: rtl/toggle_hs_receiver.sv
// Receiver for a two-phase toggle handshake: detects each request flip, holds the
// captured word on a valid/ready port and answers with an acknowledge flip.
module toggle_hs_receiver #(
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CW          = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_tog,
   input  logic [DW-1:0] req_data,
   output logic          ack_tog,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [CW-1:0] xfer_count,
   output logic          err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic          reqSync;
   logic          reqPrev_q;
   logic          reqEdge;
   logic          ackTog_q, ackTog_d;
   logic [DW-1:0] outData_q, outData_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;

   // With zero stages the producer shares our clock and the toggle is used directly.
   generate
      if (SYNC_STAGES == 0) begin : gNoSync
         assign reqSync = req_tog;
      end else begin : gSync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= req_tog;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end
         assign reqSync = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign reqEdge = reqSync ^ reqPrev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         reqPrev_q <= 1'b0;
         ackTog_q  <= 1'b0;
         outData_q <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         reqPrev_q <= reqSync;
         ackTog_q  <= ackTog_d;
         outData_q <= outData_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
   end

   // A flip arriving while a word is still held is dropped and flagged, even on the drain cycle.
   always_comb begin
      state_d   = state_q;
      ackTog_d  = ackTog_q;
      outData_d = outData_q;
      count_d   = count_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (reqEdge) begin
               outData_d = req_data;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            if (reqEdge) begin
               err_d = 1'b1;
            end
            if (out_ready) begin
               state_d  = IDLE;
               ackTog_d = ~ackTog_q;
               count_d  = count_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid  = (state_q == BUSY);
   assign out_data   = outData_q;
   assign ack_tog    = ackTog_q;
   assign xfer_count = count_q;
   assign err        = err_q;

endmodule

// File: doc/toggle_hs_receiver.md
# toggle_hs_receiver

Receiving end of the two-phase (toggle) request/acknowledge handshake whose request side is a T-flip-flop: the sender flips `req_tog` once per transfer with `req_data` held stable; this block detects the flip, captures the data into an output register, presents it on a valid/ready port, and flips `ack_tog` when the data is consumed. It sits between a toggle-signalling producer (same or slower clock domain, via the optional synchronizer) and a standard valid/ready consumer. It also keeps a wrapping transfer count and a sticky protocol-error flag.

## Interface
- `DW`, 8, width of `req_data` / `out_data`
- `SYNC_STAGES`, 2, flops on `req_tog` before edge detect; legal 0..3; 0 = `req_tog` used directly (same clock domain)
- `CW`, 16, width of `xfer_count`

- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — synchronous, active-high; clears all state
- `req_tog` input 1 — request toggle; one flip = one transfer
- `req_data` input DW — transfer data; stable from before `req_tog` flip until `ack_tog` matches `req_tog`
- `ack_tog` output 1 — acknowledge toggle; flips once per consumed transfer
- `out_valid` output 1 — `out_data` holds an unconsumed transfer
- `out_data` output DW — captured data
- `out_ready` input 1 — consumer accepts when high with `out_valid`
- `xfer_count` output CW — number of consumed transfers, wraps modulo 2^CW
- `err` output 1 — sticky: request flip seen while a transfer is still pending

## Operation
- Sync chain: `req_s` = `req_tog` after SYNC_STAGES flops (or wire if 0). `req_prev` registers `req_s` every cycle. `edge` = `req_s ^ req_prev` (combinational).
- States: IDLE (no data held), BUSY (`out_valid`=1).
- IDLE: on `edge` → `out_data` <= `req_data`, `out_valid` <= 1, go BUSY. No edge → stay.
- BUSY: `out_valid` && `out_ready` → `out_valid` <= 0, `ack_tog` <= ~`ack_tog`, `xfer_count` <= +1 (wraps from 2^CW−1 to 0), go IDLE. `out_data` retains last value after drain.
- BUSY with `edge` (any cycle, including the drain cycle): `err` <= 1, the flip is dropped (no capture, no ack, `req_prev` still updates). Only `reset` clears `err`.
- `out_data` must not change while `out_valid`=1.
- Reset values: `ack_tog`=0, `out_valid`=0, `out_data`=0, `xfer_count`=0, `err`=0, all sync flops and `req_prev`=0, state IDLE.
- Reset mid-transfer: pending data discarded, no ack issued; sender must be reset together and hold `req_tog`=0 during reset (a `req_tog`=1 at reset release is decoded as a new request, by design).

## Timing
- `req_tog` flips before rising edge k: `out_valid` and `out_data` update at edge k+SYNC_STAGES (edge k for SYNC_STAGES=0).
- Consumer handshake at edge m (`out_valid`&&`out_ready` sampled high): `out_valid`=0, `ack_tog` flipped, `xfer_count` incremented, all after edge m.
- Combinational `out_ready` → state; no combinational path from `out_ready` to any output.
- Throughput with SYNC_STAGES=0, `out_ready` tied high, sender flipping `req_tog` in the cycle after seeing `ack_tog` flip: one transfer every 2 cycles.
- `err` asserts the edge after the offending `edge` is seen.

## Test plan
- Reset: hold `reset` 3 cycles with random inputs → all outputs 0 after first edge; release with `req_tog`=0 → `out_valid` stays 0 for 10 cycles.
- Single transfer, SYNC_STAGES=2: `req_data`=0xA5, flip `req_tog` before edge 5, `out_ready`=1 → `out_valid`=1/`out_data`=0xA5 after edge 7, `ack_tog`=1, `xfer_count`=1 after edge 8, `out_valid`=0.
- Backpressure: `out_ready`=0 for 6 cycles after capture → `out_valid`, `out_data`, `ack_tog` unchanged; raise `out_ready` → ack flips at that edge, count +1.
- Back-to-back, SYNC_STAGES=0: 20 transfers with data 0..19, sender reacting to each ack → consumer sees 0..19 in order, `ack_tog` flips 20 times, `xfer_count`=20, `err`=0.
- Protocol error: flip `req_tog` twice with `out_ready`=0 → first data held, `err`=1 after second flip, second data never appears; `err` stays 1 after drain until `reset`.
- Wrap: CW=4, 17 transfers → `xfer_count` goes 15 → 0 → 1.
